sd_lese_adapter: RTL and testbench

- CPU-side read front end for the SD card word reader; sits directly upstream of it.
- Accepts 32-bit word read requests from the CPU memory stage and serves hits from a small direct-mapped word cache.
- On a miss, issues exactly one Lesen pulse to the reader, captures the word on the rising edge of the reader's Fertig, fills the cache and returns the word.
- Includes a miss timeout that reports an error instead of hanging the CPU.

---
 rtl/sd_lese_adapter.sv | 148 ++++++++++++++
 tb/tb_sd_lese_adapter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_lese_adapter.sv
// CPU-side read front end for the SD word reader: direct-mapped word cache,
// single-outstanding miss handling with one Lesen pulse and a miss timeout.
module sd_lese_adapter #(
  parameter int unsigned EINTRAEGE = 8,
  parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic        Anfrage_i,
  input  logic [31:0] Adresse_i,
  input  logic        Invalidieren_i,
  output logic        Bereit_o,
  output logic [31:0] Daten_o,
  output logic        Gueltig_o,
  output logic        Fehler_o,
  output logic [31:0] SD_Adresse_o,
  output logic        SD_Lesen_o,
  input  logic [31:0] SD_Daten_i,
  input  logic        SD_Fertig_i,
  input  logic        SD_Busy_i
);
  localparam int unsigned IDX = $clog2(EINTRAEGE);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WARTE_FREI   = 3'd1;
  localparam logic [2:0] ANFRAGE      = 3'd2;
  localparam logic [2:0] WARTE_FERTIG = 3'd3;
  localparam logic [2:0] ANTWORT      = 3'd4;
  localparam logic [2:0] FEHLER_S     = 3'd5;
  localparam logic [2:0] WARTE_ENDE   = 3'd6;

  logic [2:0]           state_q, state_d;
  logic                 aktiv_q;
  logic [31:0]          req_q, req_d;
  logic [31:0]          sd_adr_q, sd_adr_d;
  logic [31:0]          daten_q, daten_d;
  logic                 gueltig_q, gueltig_d;
  logic                 fehler_q, fehler_d;
  logic [23:0]          cnt_q, cnt_d;
  logic                 fertig_q;
  logic [EINTRAEGE-1:0] valid_q, valid_d;
  logic [31:0]          data_q [EINTRAEGE];
  logic [31-IDX:0]      tag_q  [EINTRAEGE];

  logic           bereit, accept, inval, hit, fertig_flanke, fill;
  logic [IDX-1:0] acc_idx, req_idx;
  logic [23:0]    cnt_inc;

  assign bereit        = (state_q == IDLE) && aktiv_q;
  assign accept        = bereit && Anfrage_i;
  assign inval         = bereit && Invalidieren_i;
  assign acc_idx       = Adresse_i[IDX-1:0];
  assign req_idx       = req_q[IDX-1:0];
  // A same-cycle invalidation wins over the lookup, so that request misses.
  assign hit           = valid_q[acc_idx] && !inval && (tag_q[acc_idx] == Adresse_i[31:IDX]);
  assign fertig_flanke = SD_Fertig_i && !fertig_q;
  assign fill          = (state_q == WARTE_FERTIG) && fertig_flanke;
  assign cnt_inc       = cnt_q + 24'd1;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sd_adr_d  = sd_adr_q;
    daten_d   = daten_q;
    gueltig_d = 1'b0;
    fehler_d  = 1'b0;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        if (inval) valid_d = '0;
        if (accept) begin
          req_d = Adresse_i;
          if (hit) begin
            gueltig_d = 1'b1;
            daten_d   = data_q[acc_idx];
          end else begin
            sd_adr_d = Adresse_i;
            state_d  = WARTE_FREI;
          end
        end
      end
      WARTE_FREI: if (!SD_Busy_i) state_d = ANFRAGE;
      ANFRAGE: begin
        cnt_d   = '0;
        state_d = WARTE_FERTIG;
      end
      WARTE_FERTIG: begin
        cnt_d = cnt_inc;
        // Fertig edge takes priority over an expiring timeout in the same cycle.
        if (fertig_flanke) begin
          valid_d[req_idx] = 1'b1;
          daten_d          = SD_Daten_i;
          gueltig_d        = 1'b1;
          state_d          = ANTWORT;
        end else if (cnt_inc == TIMEOUT - 24'd1) begin
          daten_d  = '1;
          fehler_d = 1'b1;
          state_d  = FEHLER_S;
        end
      end
      ANTWORT:    state_d = WARTE_ENDE;
      FEHLER_S:   state_d = WARTE_ENDE;
      WARTE_ENDE: if (!SD_Fertig_i && !SD_Busy_i) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q   <= IDLE;
      aktiv_q   <= 1'b0;
      req_q     <= '0;
      sd_adr_q  <= '0;
      daten_q   <= '0;
      gueltig_q <= 1'b0;
      fehler_q  <= 1'b0;
      cnt_q     <= '0;
      fertig_q  <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      aktiv_q   <= 1'b1;
      req_q     <= req_d;
      sd_adr_q  <= sd_adr_d;
      daten_q   <= daten_d;
      gueltig_q <= gueltig_d;
      fehler_q  <= fehler_d;
      cnt_q     <= cnt_d;
      fertig_q  <= SD_Fertig_i;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge Clock_i) begin
    if (fill) begin
      data_q[req_idx] <= SD_Daten_i;
      tag_q[req_idx]  <= req_q[31:IDX];
    end
  end

  assign Bereit_o     = bereit;
  assign Daten_o      = daten_q;
  assign Gueltig_o    = gueltig_q;
  assign Fehler_o     = fehler_q;
  assign SD_Adresse_o = sd_adr_q;
  assign SD_Lesen_o   = (state_q == ANFRAGE);
endmodule

// File: tb/tb_sd_lese_adapter.sv
// Bench for sd_lese_adapter: reactive SD reader model, address-keyed cache
// model with response scoreboard, plus a second instance for the timeout path.
module tb_sd_lese_adapter;
  localparam int NE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        anf, inv, bereit, gueltig, fehler, sd_lesen, sd_fertig, sd_busy;
  logic [31:0] adr, daten, sd_adr, sd_daten;

  logic        t_anf, t_bereit, t_gueltig, t_fehler, t_lesen;
  logic [31:0] t_adr, t_daten, t_sd_adr;
  logic        t_fertig = 1'b0;
  logic        t_busy   = 1'b0;
  logic        t_inv    = 1'b0;
  logic [31:0] t_sd_daten = 32'h1234_5678;

  sd_lese_adapter #(.EINTRAEGE(NE), .TIMEOUT(24'd1000)) u_dut (
    .Clock_i(clk), .Reset_i(rst_n), .Anfrage_i(anf), .Adresse_i(adr),
    .Invalidieren_i(inv), .Bereit_o(bereit), .Daten_o(daten), .Gueltig_o(gueltig),
    .Fehler_o(fehler), .SD_Adresse_o(sd_adr), .SD_Lesen_o(sd_lesen),
    .SD_Daten_i(sd_daten), .SD_Fertig_i(sd_fertig), .SD_Busy_i(sd_busy));

  sd_lese_adapter #(.EINTRAEGE(NE), .TIMEOUT(24'd100)) u_to (
    .Clock_i(clk), .Reset_i(rst_n), .Anfrage_i(t_anf), .Adresse_i(t_adr),
    .Invalidieren_i(t_inv), .Bereit_o(t_bereit), .Daten_o(t_daten), .Gueltig_o(t_gueltig),
    .Fehler_o(t_fehler), .SD_Adresse_o(t_sd_adr), .SD_Lesen_o(t_lesen),
    .SD_Daten_i(t_sd_daten), .SD_Fertig_i(t_fertig), .SD_Busy_i(t_busy));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Word the reader returns for a given address.
  function automatic logic [31:0] sd_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return (a * 32'h0101_0101) ^ 32'h5A00_00C3;
  endfunction

  // SD reader model controls (written by the main process only)
  int m_lat = 300;
  int m_stale = 0;
  bit m_never = 1'b0;
  int m_hold = 150;
  int pre_req = 0;

  initial begin : sd_model
    int pre_seen;
    int lat, stale;
    bit never;
    logic [31:0] a;
    pre_seen = 0;
    sd_busy = 1'b0; sd_fertig = 1'b0; sd_daten = '0;
    forever begin
      @(negedge clk);
      if (pre_req != pre_seen) begin
        pre_seen = pre_req;
        @(posedge clk); #1;
        sd_busy = 1'b1; sd_fertig = 1'b1; sd_daten = 32'hBAD0_BAD0;
        repeat (50) @(posedge clk);
        #1 sd_busy = 1'b0;
      end else if (rst_n && sd_lesen) begin
        never = m_never; lat = m_lat; stale = m_stale; a = sd_adr;
        @(posedge clk); #1 sd_busy = 1'b1;
        if (never) begin
          repeat (m_hold) @(posedge clk);
          #1 sd_busy = 1'b0; sd_fertig = 1'b0;
        end else begin
          for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            if (i == stale) sd_fertig = 1'b0;
          end
          @(posedge clk); #1;
          sd_daten = sd_word(a); sd_fertig = 1'b1;
          repeat (4) @(posedge clk);
          #1 sd_fertig = 1'b0; sd_daten = 32'h0BAD_0BAD;
          repeat (3) @(posedge clk);
          #1 sd_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    bit          err;
    logic [31:0] data;
    int          acc_cyc;
    int          lesen0;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_cache [logic [31:0]];
  logic [31:0] kill[$];
  exp_t        e;
  int          cyc = 0;
  int          lesen_cnt = 0;
  logic [31:0] last_daten = '0;
  int          last_lat = 0;
  bit          lesen_prev = 1'b0, bereit_prev = 1'b0, busy_prev = 1'b0, fertig_prev = 1'b0;
  bit          after_miss = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      m_cache.delete();
      after_miss = 1'b0;
    end else begin
      if (sd_lesen) begin
        lesen_cnt++;
        chk("lesen_while_busy", 32'(sd_busy), 32'd0);
        chk("lesen_consecutive", 32'(lesen_prev), 32'd0);
        chk("lesen_outstanding", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) chk("lesen_sd_adresse", sd_adr, sb[0].addr);
      end
      if (bereit && !bereit_prev && after_miss) begin
        chk("bereit_after_reader_idle", 32'(busy_prev | fertig_prev), 32'd0);
        after_miss = 1'b0;
      end
      if (gueltig || fehler) begin
        chk("gueltig_fehler_exclusive", 32'(gueltig & fehler), 32'd0);
        chk("resp_outstanding", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_kind_fehler", 32'(fehler), 32'(e.err));
          chk("resp_daten", daten, e.data);
          last_daten = daten;
          last_lat   = cyc - e.acc_cyc;
          if (e.hit) begin
            chk("hit_latency", 32'(cyc - e.acc_cyc), 32'd1);
            chk("hit_no_lesen", 32'(lesen_cnt - e.lesen0), 32'd0);
          end else begin
            chk("miss_one_lesen", 32'(lesen_cnt - e.lesen0), 32'd1);
            chk("miss_sd_adresse", sd_adr, e.addr);
            after_miss = 1'b1;
            if (!e.err) begin
              kill.delete();
              foreach (m_cache[k]) if ((k % NE) == (e.addr % NE)) kill.push_back(k);
              foreach (kill[j]) m_cache.delete(kill[j]);
              m_cache[e.addr] = e.data;
            end
          end
        end
      end
      if (inv && bereit) m_cache.delete();
      if (anf && bereit) begin
        e.addr    = adr;
        e.hit     = m_cache.exists(adr);
        e.err     = !e.hit && m_never;
        e.data    = e.hit ? m_cache[adr] : (e.err ? 32'hFFFF_FFFF : sd_word(adr));
        e.acc_cyc = cyc;
        e.lesen0  = lesen_cnt;
        sb.push_back(e);
      end
    end
    lesen_prev  = sd_lesen;
    bereit_prev = bereit;
    busy_prev   = sd_busy;
    fertig_prev = sd_fertig;
  end

  task automatic request(input logic [31:0] a, input bit with_inv);
    int n;
    @(posedge clk); #1 anf = 1'b1; adr = a; inv = with_inv;
    n = 0;
    do begin @(negedge clk); n++; end while (!bereit && n < 3000);
    chk("accept_wait", 32'(bereit), 32'd1);
    @(posedge clk); #1 anf = 1'b0; inv = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((sb.size() != 0 || !bereit) && n < 5000);
    chk("response_wait", 32'(sb.size() == 0 && bereit), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bereit"}, 32'(bereit), 32'd0);
    chk({tag, "_gueltig"}, 32'(gueltig), 32'd0);
    chk({tag, "_fehler"}, 32'(fehler), 32'd0);
    chk({tag, "_daten"}, daten, 32'd0);
    chk({tag, "_sd_lesen"}, 32'(sd_lesen), 32'd0);
    chk({tag, "_sd_adresse"}, sd_adr, 32'd0);
  endtask

  initial begin : main
    int l0, n, k;
    bit seen_g;
    anf = 1'b0; adr = '0; inv = 1'b0; t_anf = 1'b0; t_adr = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("bereit_in_release_cycle", 32'(bereit), 32'd0);
    @(negedge clk); chk("bereit_after_release", 32'(bereit), 32'd1);

    // first miss, reader answers 300 cycles after Lesen
    l0 = lesen_cnt;
    request(32'h10, 1'b0); wait_done();
    chk("t1_lesen_count", 32'(lesen_cnt - l0), 32'd1);
    chk("t1_daten", last_daten, 32'hDEAD_BEEF);
    chk("t1_sd_adresse", sd_adr, 32'h10);

    // repeat is a one-cycle hit
    l0 = lesen_cnt;
    request(32'h10, 1'b0); wait_done();
    chk("t2_lesen_count", 32'(lesen_cnt - l0), 32'd0);
    chk("t2_daten", last_daten, 32'hDEAD_BEEF);
    chk("t2_latency", 32'(last_lat), 32'd1);

    // back-to-back hits
    m_lat = 40;
    request(32'h11, 1'b0); wait_done();
    l0 = lesen_cnt;
    @(posedge clk); #1 anf = 1'b1; adr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!bereit && n < 100);
    @(posedge clk); #1 adr = 32'h11;
    @(negedge clk);
    chk("b2b_bereit", 32'(bereit), 32'd1);
    chk("b2b_gueltig", 32'(gueltig), 32'd1);
    @(posedge clk); #1 anf = 1'b0;
    wait_done();
    chk("b2b_lesen_count", 32'(lesen_cnt - l0), 32'd0);
    chk("b2b_daten_second", last_daten, sd_word(32'h11));

    // same index, different tag evicts
    l0 = lesen_cnt;
    request(32'h18, 1'b0); wait_done();
    request(32'h10, 1'b0); wait_done();
    chk("t3_lesen_count", 32'(lesen_cnt - l0), 32'd2);
    chk("t3_daten", last_daten, 32'hDEAD_BEEF);

    // reader busy for 50 cycles with a stale Fertig level
    m_lat = 60; m_stale = 20;
    pre_req++;
    repeat (3) @(posedge clk);
    l0 = lesen_cnt;
    request(32'h23, 1'b0);
    repeat (40) @(negedge clk);
    chk("t4_no_lesen_while_busy", 32'(lesen_cnt - l0), 32'd0);
    wait_done();
    chk("t4_lesen_count", 32'(lesen_cnt - l0), 32'd1);
    chk("t4_daten_not_stale", last_daten, sd_word(32'h23));
    m_stale = 0; m_lat = 40;

    // invalidation alone, then together with a request
    @(posedge clk); #1 inv = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 inv = 1'b0;
    l0 = lesen_cnt;
    request(32'h10, 1'b0); wait_done();
    chk("t5_miss_after_inv", 32'(lesen_cnt - l0), 32'd1);
    l0 = lesen_cnt;
    request(32'h10, 1'b1); wait_done();
    chk("t5_miss_same_cycle_inv", 32'(lesen_cnt - l0), 32'd1);
    chk("t5_daten", last_daten, 32'hDEAD_BEEF);

    // reset while waiting for Fertig
    m_never = 1'b1; m_hold = 150;
    l0 = lesen_cnt;
    request(32'h11, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (lesen_cnt == l0 && n < 100);
    chk("t6_lesen_seen", 32'(lesen_cnt - l0), 32'd1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset");
    m_never = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("t6_bereit_release_cycle", 32'(bereit), 32'd0);
    @(negedge clk); chk("t6_bereit_after_release", 32'(bereit), 32'd1);
    l0 = lesen_cnt;
    request(32'h10, 1'b0); wait_done();
    chk("t6_cache_empty_miss", 32'(lesen_cnt - l0), 32'd1);
    chk("t6_daten", last_daten, 32'hDEAD_BEEF);

    // timeout instance: reader never raises Fertig
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1 t_anf = 1'b1; t_adr = 32'h20;
      n = 0;
      do begin @(negedge clk); n++; end while (!t_bereit && n < 300);
      chk("to_accept_wait", 32'(t_bereit), 32'd1);
      @(posedge clk); #1 t_anf = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!t_lesen && n < 50);
      chk("to_lesen_seen", 32'(t_lesen), 32'd1);
      k = 0; seen_g = 1'b0;
      do begin
        @(negedge clk); k++;
        if (t_gueltig) seen_g = 1'b1;
      end while (!t_fehler && k < 300);
      chk("to_fehler_latency", 32'(k), 32'd100);
      chk("to_daten", t_daten, 32'hFFFF_FFFF);
      chk("to_no_gueltig", 32'(seen_g), 32'd0);
      @(negedge clk);
      chk("to_fehler_one_cycle", 32'(t_fehler), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
